// File: rtl/nibble_serial_pkg.sv
// Shared constants, state encoding and sizing helper for the nibble-serial adder.
package nibble_serial_pkg;

   localparam int NIBBLE_W = 4;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = IDLE,
      ST_RUN  = RUN,
      ST_DONE = DONE
   } state_e;

   // Width needed to index 'value' items; never less than one bit.
   function automatic int clog2(input int value);
      int res;
      res = 0;
      while ((1 << res) < value) begin
         res = res + 1;
      end
      if (res < 1) begin
         res = 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/parallel_adder.sv
// 4-bit ripple-carry adder: the single per-nibble datapath reused every cycle.
module parallel_adder
   import nibble_serial_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a_i,
   input  logic [NIBBLE_W-1:0] b_i,
   input  logic                c_i,
   output logic [NIBBLE_W-1:0] s_o,
   output logic                c_o
);

   logic [NIBBLE_W:0] carry;

   // Full-adder chain, carry rippling from bit 0 upward.
   always_comb begin
      carry    = '0;
      s_o      = '0;
      carry[0] = c_i;
      for (int i = 0; i < NIBBLE_W; i++) begin
         s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
         carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
      end
      c_o = carry[NIBBLE_W];
   end

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that sequences operands one nibble per clock through one 4-bit adder.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. in_ready/out_valid come from registered state only, so neither
// depends combinationally on in_valid or out_ready. Once a result is offered,
// out_valid stays high and sum/cout stay stable until out_ready is seen.
module nibble_serial_adder
   import nibble_serial_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [NIBBLE_W*NIBBLES-1:0]   a,
   input  logic [NIBBLE_W*NIBBLES-1:0]   b,
   input  logic                          cin,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [NIBBLE_W*NIBBLES-1:0]   sum,
   output logic                          cout,
   output state_e                        dbg_state_o
);

   localparam int W     = NIBBLE_W * NIBBLES;
   localparam int IDX_W = clog2(NIBBLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_e              state_q;
   logic [IDX_W-1:0]    idx_q;
   logic                carry_q;
   logic [W-1:0]        a_q;
   logic [W-1:0]        b_q;
   logic [W-1:0]        sum_q;
   logic [W-1:0]        sum_d;
   logic                cout_q;
   logic                in_ready_q;
   logic                out_valid_q;

   logic [NIBBLE_W-1:0] nib_a;
   logic [NIBBLE_W-1:0] nib_b;
   logic [NIBBLE_W-1:0] nib_s;
   logic                nib_c;

   // Pick the operand nibbles addressed by the index counter.
   always_comb begin
      nib_a = '0;
      nib_b = '0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx_q == IDX_W'(i)) begin
            nib_a = a_q[i*NIBBLE_W +: NIBBLE_W];
            nib_b = b_q[i*NIBBLE_W +: NIBBLE_W];
         end
      end
   end

   parallel_adder u_nibble_adder (
      .a_i (nib_a),
      .b_i (nib_b),
      .c_i (carry_q),
      .s_o (nib_s),
      .c_o (nib_c)
   );

   // Drop the freshly computed nibble into its slot of the running sum.
   always_comb begin
      sum_d = sum_q;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx_q == IDX_W'(i)) begin
            sum_d[i*NIBBLE_W +: NIBBLE_W] = nib_s;
         end
      end
   end

   // Control FSM plus all datapath registers; flags are registered with the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  a_q        <= a;
                  b_q        <= b;
                  carry_q    <= cin;
                  sum_q      <= '0;
                  cout_q     <= 1'b0;
                  idx_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= ST_RUN;
               end
            end
            ST_RUN: begin
               sum_q   <= sum_d;
               carry_q <= nib_c;
               if (idx_q == LAST_IDX) begin
                  // Index holds at the last nibble rather than wrapping.
                  cout_q      <= nib_c;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end else begin
                  idx_q <= idx_q + IDX_W'(1);
               end
            end
            ST_DONE: begin
               // Retiring costs one edge; the next accept needs another.
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign sum         = sum_q;
   assign cout        = cout_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder at NIBBLES=4 and NIBBLES=1.
module tb_nibble_serial_adder;
   import nibble_serial_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- DUT, NIBBLES=4 ----------------
   logic        in_valid, in_ready, cin, out_valid, out_ready, cout;
   logic [15:0] a, b, sum;
   state_e      dbg_state;

   nibble_serial_adder #(.NIBBLES(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .cin         (cin),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .sum         (sum),
      .cout        (cout),
      .dbg_state_o (dbg_state)
   );

   // ---------------- DUT, NIBBLES=1 ----------------
   logic        in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1;
   logic [3:0]  a1, b1, sum1;
   state_e      dbg_state1;

   nibble_serial_adder #(.NIBBLES(1)) dut1 (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid1),
      .in_ready    (in_ready1),
      .a           (a1),
      .b           (b1),
      .cin         (cin1),
      .out_valid   (out_valid1),
      .out_ready   (out_ready1),
      .sum         (sum1),
      .cout        (cout1),
      .dbg_state_o (dbg_state1)
   );

   int total = 0;
   int bad   = 0;

   // ---------------- driver tasks ----------------
   task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic cv);
      a        = av;
      b        = bv;
      cin      = cv;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = -1;
      for (int n = 1; n <= 30; n++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic retire();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (sum !== 16'h0000) begin bad++; $display("FAIL reset_sum got=%h exp=0000", sum); end
      total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b exp=0", cout); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL reset_in_ready1 got=%b exp=1", in_ready1); end
   endtask

   task automatic test_basic();
      int lat;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_pre_ready got=%b exp=1", in_ready); end
      send(16'h1234, 16'h4321, 1'b0);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_after_accept got=%b exp=0", out_valid); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_in_run got=%b exp=0", in_ready); end
      wait_out(lat);
      total++; if (lat !== 4) begin bad++; $display("FAIL basic_latency got=%0d exp=4", lat); end
      total++; if (sum !== 16'h5555) begin bad++; $display("FAIL basic_sum got=%h exp=5555", sum); end
      total++; if (cout !== 1'b0) begin bad++; $display("FAIL basic_cout got=%b exp=0", cout); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_in_done got=%b exp=0", in_ready); end
      retire();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_after_retire got=%b exp=0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_after_retire got=%b exp=1", in_ready); end
      total++; if (sum !== 16'h5555) begin bad++; $display("FAIL basic_sum_held got=%h exp=5555", sum); end
   endtask

   task automatic test_carry();
      int lat;
      send(16'hFFFF, 16'h0001, 1'b0);
      wait_out(lat);
      total++; if (lat !== 4) begin bad++; $display("FAIL ripple_latency got=%0d exp=4", lat); end
      total++; if (sum !== 16'h0000) begin bad++; $display("FAIL ripple_sum got=%h exp=0000", sum); end
      total++; if (cout !== 1'b1) begin bad++; $display("FAIL ripple_cout got=%b exp=1", cout); end
      retire();
      send(16'hFFFF, 16'hFFFF, 1'b1);
      wait_out(lat);
      total++; if (sum !== 16'hFFFF) begin bad++; $display("FAIL allones_sum got=%h exp=ffff", sum); end
      total++; if (cout !== 1'b1) begin bad++; $display("FAIL allones_cout got=%b exp=1", cout); end
      retire();
      send(16'h0000, 16'h0000, 1'b1);
      wait_out(lat);
      total++; if (sum !== 16'h0001) begin bad++; $display("FAIL cin_only_sum got=%h exp=0001", sum); end
      total++; if (cout !== 1'b0) begin bad++; $display("FAIL cin_only_cout got=%b exp=0", cout); end
      retire();
   endtask

   task automatic test_backpressure();
      int lat;
      send(16'h00FF, 16'h0001, 1'b0);
      wait_out(lat);
      total++; if (lat !== 4) begin bad++; $display("FAIL bp_latency got=%0d exp=4", lat); end
      for (int k = 0; k < 5; k++) begin
         if (k == 1) begin
            a        = 16'hAAAA;
            b        = 16'h5555;
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk); #1;
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_held cyc=%0d got=%b exp=1", k, out_valid); end
         total++; if (sum !== 16'h0100) begin bad++; $display("FAIL bp_sum_held cyc=%0d got=%h exp=0100", k, sum); end
         total++; if (cout !== 1'b0) begin bad++; $display("FAIL bp_cout_held cyc=%0d got=%b exp=0", k, cout); end
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_low cyc=%0d got=%b exp=0", k, in_ready); end
      end
      in_valid = 1'b0;
      retire();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_idle_ready got=%b exp=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_idle_valid got=%b exp=0", out_valid); end
      send(16'h0001, 16'h0001, 1'b0);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_next_accepted got=%b exp=0", in_ready); end
      wait_out(lat);
      total++; if (sum !== 16'h0002) begin bad++; $display("FAIL bp_next_sum got=%h exp=0002", sum); end
      retire();
   endtask

   task automatic test_reset_mid();
      int lat;
      send(16'h1234, 16'h4321, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      total++; if (sum !== 16'h0000) begin bad++; $display("FAIL midrst_sum got=%h exp=0000", sum); end
      total++; if (cout !== 1'b0) begin bad++; $display("FAIL midrst_cout got=%b exp=0", cout); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
      total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL midrst_state got=%0d exp=0", dbg_state); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", in_ready); end
      send(16'h0F0F, 16'h00F1, 1'b0);
      wait_out(lat);
      total++; if (lat !== 4) begin bad++; $display("FAIL midrst_latency got=%0d exp=4", lat); end
      total++; if (sum !== 16'h1000) begin bad++; $display("FAIL midrst_sum_after got=%h exp=1000", sum); end
      total++; if (cout !== 1'b0) begin bad++; $display("FAIL midrst_cout_after got=%b exp=0", cout); end
      retire();
   endtask

   task automatic test_back_to_back();
      logic [16:0] exp_q[$];
      logic [15:0] sa [3];
      logic [15:0] sb [3];
      logic        sc [3];
      logic [16:0] se [3];
      logic [16:0] exp_v;
      logic        accept;
      int sent = 0;
      int got = 0;
      int cyc = 0;
      int last_cyc = -1;
      int extra = 0;
      sa[0] = 16'h1111; sb[0] = 16'h2222; sc[0] = 1'b0; se[0] = {1'b0, 16'h3333};
      sa[1] = 16'h8000; sb[1] = 16'h8000; sc[1] = 1'b1; se[1] = {1'b1, 16'h0001};
      sa[2] = 16'hABCD; sb[2] = 16'h1234; sc[2] = 1'b1; se[2] = {1'b0, 16'hBE02};
      out_ready = 1'b1;
      a = sa[0]; b = sb[0]; cin = sc[0]; in_valid = 1'b1;
      while (got < 3 && cyc < 80) begin
         accept = in_ready && in_valid;
         if (accept) exp_q.push_back(se[sent]);
         @(posedge clk); #1;
         cyc++;
         if (accept) begin
            sent++;
            if (sent < 3) begin
               a = sa[sent]; b = sb[sent]; cin = sc[sent];
            end else begin
               in_valid = 1'b0;
            end
         end
         if (out_valid) begin
            got++;
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL stream_unexpected_result got=%h", {cout, sum});
            end else begin
               exp_v = exp_q.pop_front();
               total++; if ({cout, sum} !== exp_v) begin bad++; $display("FAIL stream_result n=%0d got=%h exp=%h", got, {cout, sum}, exp_v); end
            end
            if (last_cyc >= 0) begin
               total++; if (cyc - last_cyc !== 6) begin bad++; $display("FAIL stream_interval n=%0d got=%0d exp=6", got, cyc - last_cyc); end
            end
            last_cyc = cyc;
         end
      end
      in_valid = 1'b0;
      total++; if (got !== 3) begin bad++; $display("FAIL stream_count got=%0d exp=3", got); end
      total++; if (sent !== 3) begin bad++; $display("FAIL stream_sent got=%0d exp=3", sent); end
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (out_valid) extra++;
      end
      total++; if (extra !== 0) begin bad++; $display("FAIL stream_extra_results got=%0d exp=0", extra); end
      out_ready = 1'b0;
   endtask

   task automatic test_nibbles1();
      total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL n1_pre_ready got=%b exp=1", in_ready1); end
      a1 = 4'h9; b1 = 4'h8; cin1 = 1'b1; in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      total++; if (out_valid1 !== 1'b0) begin bad++; $display("FAIL n1_valid_in_run got=%b exp=0", out_valid1); end
      @(posedge clk); #1;
      total++; if (out_valid1 !== 1'b1) begin bad++; $display("FAIL n1_latency got=%b exp=1", out_valid1); end
      total++; if (sum1 !== 4'h2) begin bad++; $display("FAIL n1_sum got=%h exp=2", sum1); end
      total++; if (cout1 !== 1'b1) begin bad++; $display("FAIL n1_cout got=%b exp=1", cout1); end
      out_ready1 = 1'b1;
      @(posedge clk); #1;
      out_ready1 = 1'b0;
      total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL n1_ready_after got=%b exp=1", in_ready1); end
      a1 = 4'h3; b1 = 4'h4; cin1 = 1'b0; in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      @(posedge clk); #1;
      total++; if ({cout1, sum1} !== 5'h07) begin bad++; $display("FAIL n1_second got=%h exp=07", {cout1, sum1}); end
      out_ready1 = 1'b1;
      @(posedge clk); #1;
      out_ready1 = 1'b0;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
      in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
      test_reset();
      test_basic();
      test_carry();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_nibbles1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-cycle wide-operand adder. It accepts two (4*NIBBLES)-bit operands plus carry-in over a valid/ready handshake, then pushes one nibble per clock through a single 4-bit ripple-carry adder, least-significant nibble first. The carry is held in a register between nibbles. It sits directly upstream of the 4-bit adder, sequencing its operands and collecting its sum/carry, so wide additions reuse one small adder.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..16

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a/b/cin valid
in_ready  output  1  block can accept operands
a  input  W  operand A
b  input  W  operand B
cin  input  1  carry-in to least-significant nibble
out_valid  output  1  sum/cout valid
out_ready  input  1  consumer accepts result
sum  output  W  registered sum
cout  output  1  registered carry-out of most-significant nibble

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, nibble index=0, carry reg=0.
  - Operand regs=0, sum=0, cout=0, out_valid=0.
  - in_ready=1 once reset is deasserted.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On a clk edge with in_valid=1: latch a, b into operand regs; carry reg<=cin; sum<=0; cout<=0; index<=0; go RUN.
  - Otherwise stay in IDLE.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge: the 4-bit adder adds a_reg[4i+3:4i], b_reg[4i+3:4i] and the carry reg.
  - Result nibble is written to sum[4i+3:4i]; carry reg<=adder carry-out; index<=index+1.
  - On the edge that processes index NIBBLES-1: cout<=adder carry-out; go DONE.
  - in_valid is ignored while in RUN.
- DONE:
  - out_valid=1, in_ready=0.
  - sum and cout are held stable.
  - On an edge with out_ready=1: go IDLE. sum/cout keep their values until the next accept.
- Latency:
  - Accept edge T0; nibbles are processed on edges T1..TNIBBLES.
  - out_valid rises after edge TNIBBLES.
  - Minimum issue interval is NIBBLES+2 cycles (DONE->IDLE costs one edge; accept needs another).
- No same-cycle accept on result handoff: in_ready=0 in DONE, so a new operand cannot be accepted on the edge that retires a result.
- Arithmetic:
  - Unsigned, modulo 2^W.
  - cout is the true carry of a+b+cin.
  - No overflow flag.
- NIBBLES=1: RUN lasts exactly one edge.
- Index counter width is clog2(NIBBLES), minimum 1. The counter never wraps past NIBBLES-1.
- Reset mid-operation (any state): abort immediately, all outputs go to their reset values, and the partial result is discarded.
- in_ready and out_valid are decoded from the state register only. There is no combinational path from in_valid or out_ready.

Decomposition:
- Package nibble_serial_pkg holds:
  - NIBBLE_W = 4.
  - State encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Function clog2 for sizing the index counter.
- Sub-module: one instance of the existing 4-bit ripple-carry parallel_adder as the per-nibble datapath.
- Nibble select/insert muxes and the FSM stay in the top module.

Test Plan:
1. NIBBLES=4, a=16'h1234, b=16'h4321, cin=0 -> sum=16'h5555, cout=0. out_valid rises exactly 4 edges after the accept edge.
2. a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1. Confirms the carry ripples through the carry reg across all nibbles.
3. a=16'hFFFF, b=16'hFFFF, cin=1 -> sum=16'hFFFF, cout=1. Then a=0, b=0, cin=1 -> sum=16'h0001, cout=0.
4. Backpressure on result a=16'h00FF, b=16'h0001, cin=0 (result sum=16'h0100, cout=0):
   - Hold out_ready=0 for 5 cycles after out_valid rises -> out_valid, sum=16'h0100 and cout=0 stay stable; in_ready=0.
   - in_valid pulsed with a=16'hAAAA is ignored.
   - Raise out_ready -> IDLE next edge; next operand accepted one edge later.
5. Reset mid-RUN: assert rst_n=0 two edges after accepting 16'h1234+16'h4321.
   - Required: sum=0, cout=0, out_valid=0 immediately.
   - After release: in_ready=1; a=16'h0F0F, b=16'h00F1, cin=0 -> sum=16'h1000, cout=0.
6. Streaming: in_valid and out_ready held high with 3 consecutive operand pairs -> one result every 6 cycles, each result correct, no operand dropped or duplicated. Repeat with NIBBLES=1: a=4'h9, b=4'h8, cin=1 -> sum=4'h2, cout=1, out_valid one edge after accept.
